trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Machine-mode trap sequencer between the core pipeline and the CSR unit.
- Arbitrates synchronous exceptions against pending M-mode external and timer interrupts.
- Sequences the CSR writes for trap entry (mepc, mcause, mtval, mstatus) and for mret (mstatus), one write per cycle.
- Stalls the pipeline during the sequence, then issues a PC redirect to the trap vector or to mepc.

Parameters:
- MTVEC, 32'h8000_0004, trap vector redirect address; equals HARDCODED_MTVEC.
- XLEN, 32, data width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- boundary_i  in  1  instruction boundary; trap/mret may be accepted this cycle.
- exc_req_i  in  1  synchronous exception present at the boundary.
- exc_code_i  in  32  exception cause (M_ILL_INSTR, M_ECALL, ...).
- exc_tval_i  in  XLEN  faulting address or instruction.
- trap_pc_i  in  XLEN  faulting PC for exceptions, next PC for interrupts.
- mret_i  in  1  mret at the boundary.
- mstatus_i  in  XLEN  current mstatus (mstatus_csr_t).
- mie_i  in  XLEN  current mie (mie_csr_t).
- mip_i  in  XLEN  current mip (mip_csr_t).
- mepc_i  in  XLEN  current mepc, used by mret.
- stall_o  out  1  pipeline hold.
- csr_we_o  out  1  CSR write strobe.
- csr_waddr_o  out  12  CSR number (csr_num_t).
- csr_wdata_o  out  XLEN  CSR write data.
- redirect_o  out  1  one-cycle PC redirect strobe.
- redirect_pc_o  out  XLEN  redirect target.
- trap_taken_o  out  1  one-cycle pulse at trap acceptance.

Behaviour:
- Reset values: all outputs 0, state IDLE, capture registers 0.
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS, REDIRECT.
- Acceptance happens only in IDLE with boundary_i=1. Priority, highest first:
  1. exc_req_i.
  2. External interrupt: mstatus.mie & mie.meie & mip.meip → cause M_EXT_INT.
  3. Timer interrupt: mstatus.mie & mie.mtie & mip.mtip → cause M_TIMER_INT.
  4. mret_i.
- Trap accepted (cycle 0):
  - Capture cause, trap_pc_i, and tval (exc_tval_i for exceptions, 0 for interrupts).
  - Capture mstatus_i.
  - Pulse trap_taken_o (combinational in cycle 0). Go to W_EPC.
- mret accepted (cycle 0): capture mstatus_i, go to M_STATUS.
- stall_o=1 in every non-IDLE state, including REDIRECT.
- Writes use registered outputs, csr_we_o=1 for exactly one cycle per state:
  - W_EPC: CSR_MEPC ← captured pc with bits [1:0] forced to 0.
  - W_CAUSE: CSR_MCAUSE ← captured cause.
  - W_TVAL: CSR_MTVAL ← captured tval.
  - W_STATUS: CSR_MSTATUS ← captured value with mpie=mie, mie=0, mpp=2'b11; other fields unchanged.
  - M_STATUS: CSR_MSTATUS ← captured value with mie=mpie, mpie=1, mpp=2'b11.
- REDIRECT:
  - redirect_o=1; redirect_pc_o=MTVEC for a trap, mepc_i for an mret.
  - Then return to IDLE.
- Latency from acceptance to redirect: trap 5 cycles (redirect in cycle 5); mret 2 cycles.
- Inputs arriving while not in IDLE are ignored; the upstream holds them via stall_o.
- exc_req_i together with mret_i: exception wins, mret dropped.
- Interrupt together with mret_i: interrupt taken, mret discarded. mepc = trap_pc_i (supplied by the core as the mret's own PC), so the mret re-executes after the handler.
- mstatus.mie=0: interrupts masked; exceptions are still taken.
- boundary_i=0: nothing is accepted, including exc_req_i.
- Reset mid-sequence: immediate return to IDLE; outputs cleared, no further writes. Partial CSR writes already issued are not undone.
- csr_wdata_o/csr_waddr_o are 0 when csr_we_o=0.

Decomposition:
- Package: csr_num_t, mstatus_csr_t, mie_csr_t, mip_csr_t, M_EXT_INT, M_TIMER_INT, exception codes, HARDCODED_MTVEC.
- Add to package: trap_state_t enum with the seven states above.
- Optional sub-module trap_prio_enc: combinational priority select from exc_req/mip/mie/mstatus, returning {valid, is_irq, cause}.

Test Plan:
1. Illegal instruction: boundary_i=1, exc_req_i=1, exc_code_i=2, trap_pc_i=0x8000_0100, exc_tval_i=0x0000_FFFF, mstatus.mie=1.
   - Writes in order: mepc=0x8000_0100, mcause=2, mtval=0xFFFF, mstatus mie=0/mpie=1/mpp=3.
   - Redirect to 0x8000_0004 in cycle 5; stall_o high cycles 1–5.
2. External vs timer: mip.meip=1, mip.mtip=1, mie=0x880, mstatus.mie=1, trap_pc_i=0x8000_0200.
   - mcause=0x8000_000B, mtval=0, mepc=0x8000_0200.
3. Interrupt masked: same as scenario 2 with mstatus.mie=0 → no trap, stall_o stays 0. Then assert exc_req_i code 11 (ECALL) → trap taken, mcause=11.
4. mret: mstatus mpie=1, mie=0, mepc_i=0x8000_0300.
   - Cycle 1 mstatus write with mie=1, mpie=1.
   - Cycle 2 redirect to 0x8000_0300.
5. Simultaneous and busy inputs:
   - exc_req_i and mret_i together → exception sequence only.
   - exc_req_i pulsed during W_CAUSE → ignored; exactly 4 writes and 1 redirect.
6. Reset mid-sequence: deassert rst_n during W_TVAL → all outputs 0 immediately, no mstatus write. After release, IDLE accepts a new trap normally.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared types for the machine-mode trap sequencer.
//   csr_num_t      - CSR numbers written by the sequencer
//   mstatus/mie/mip - RV32 machine CSR field layouts
//   mcause_t       - exception and interrupt cause codes
//   trap_state_t   - sequencer states
//   trap_entry_status / mret_status - mstatus rewrite helpers
package trap_ctrl_pkg;

  localparam logic [31:0] HARDCODED_MTVEC = 32'h8000_0004;

  typedef enum logic [11:0] {
    CSR_MSTATUS = 12'h300,
    CSR_MIE     = 12'h304,
    CSR_MTVEC   = 12'h305,
    CSR_MEPC    = 12'h341,
    CSR_MCAUSE  = 12'h342,
    CSR_MTVAL   = 12'h343,
    CSR_MIP     = 12'h344
  } csr_num_t;

  typedef enum logic [31:0] {
    M_INSTR_MISALIGN = 32'd0,
    M_INSTR_FAULT    = 32'd1,
    M_ILL_INSTR      = 32'd2,
    M_BREAKPOINT     = 32'd3,
    M_LOAD_MISALIGN  = 32'd4,
    M_LOAD_FAULT     = 32'd5,
    M_STORE_MISALIGN = 32'd6,
    M_STORE_FAULT    = 32'd7,
    M_ECALL          = 32'd11,
    M_TIMER_INT      = 32'h8000_0007,
    M_EXT_INT        = 32'h8000_000B
  } mcause_t;

  typedef struct packed {
    logic [18:0] rsvd_31_13;
    logic [1:0]  mpp;        // [12:11]
    logic [2:0]  rsvd_10_8;
    logic        mpie;       // [7]
    logic [2:0]  rsvd_6_4;
    logic        mie;        // [3]
    logic [2:0]  rsvd_2_0;
  } mstatus_csr_t;

  typedef struct packed {
    logic [19:0] rsvd_31_12;
    logic        meie;       // [11]
    logic [2:0]  rsvd_10_8;
    logic        mtie;       // [7]
    logic [2:0]  rsvd_6_4;
    logic        msie;       // [3]
    logic [2:0]  rsvd_2_0;
  } mie_csr_t;

  typedef struct packed {
    logic [19:0] rsvd_31_12;
    logic        meip;       // [11]
    logic [2:0]  rsvd_10_8;
    logic        mtip;       // [7]
    logic [2:0]  rsvd_6_4;
    logic        msip;       // [3]
    logic [2:0]  rsvd_2_0;
  } mip_csr_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_TVAL   = 3'd3,
    W_STATUS = 3'd4,
    M_STATUS = 3'd5,
    REDIRECT = 3'd6
  } trap_state_t;

  // Trap entry: stash mie into mpie, disable interrupts, previous mode = M.
  function automatic mstatus_csr_t trap_entry_status(input mstatus_csr_t s);
    mstatus_csr_t r;
    r      = s;
    r.mpie = s.mie;
    r.mie  = 1'b0;
    r.mpp  = 2'b11;
    return r;
  endfunction

  // mret: restore mie from mpie, re-arm mpie, stay in M.
  function automatic mstatus_csr_t mret_status(input mstatus_csr_t s);
    mstatus_csr_t r;
    r      = s;
    r.mie  = s.mpie;
    r.mpie = 1'b1;
    r.mpp  = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: core/CSR-side bundle of the trap sequencer.
//   Inputs to the sequencer: boundary, exception request/cause/tval, trap pc,
//   mret, and current mstatus/mie/mip/mepc.
//   Outputs: stall, one CSR write port, PC redirect, trap_taken pulse.
//   slave  - trap_ctrl side; master - core / testbench side.
interface trap_ctrl_if #(parameter int XLEN = 32);
  logic            boundary_i;
  logic            exc_req_i;
  logic [31:0]     exc_code_i;
  logic [XLEN-1:0] exc_tval_i;
  logic [XLEN-1:0] trap_pc_i;
  logic            mret_i;
  logic [XLEN-1:0] mstatus_i;
  logic [XLEN-1:0] mie_i;
  logic [XLEN-1:0] mip_i;
  logic [XLEN-1:0] mepc_i;

  logic            stall_o;
  logic            csr_we_o;
  logic [11:0]     csr_waddr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            trap_taken_o;

  modport slave (
    input  boundary_i, exc_req_i, exc_code_i, exc_tval_i, trap_pc_i, mret_i,
           mstatus_i, mie_i, mip_i, mepc_i,
    output stall_o, csr_we_o, csr_waddr_o, csr_wdata_o, redirect_o,
           redirect_pc_o, trap_taken_o
  );

  modport master (
    output boundary_i, exc_req_i, exc_code_i, exc_tval_i, trap_pc_i, mret_i,
           mstatus_i, mie_i, mip_i, mepc_i,
    input  stall_o, csr_we_o, csr_waddr_o, csr_wdata_o, redirect_o,
           redirect_pc_o, trap_taken_o
  );
endinterface

// File: rtl/trap_ctrl_prio_enc.sv
// trap_prio_enc: combinational trap source select.
//   i_exc_req/i_exc_code - synchronous exception (highest priority)
//   i_mstatus/i_mie/i_mip - interrupt enables and pending bits
//   o_valid  - some trap source is active
//   o_is_irq - selected source is an interrupt
//   o_cause  - mcause value for the selected source
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic         i_exc_req,
  input  logic [31:0]  i_exc_code,
  input  mstatus_csr_t i_mstatus,
  input  mie_csr_t     i_mie,
  input  mip_csr_t     i_mip,
  output logic         o_valid,
  output logic         o_is_irq,
  output logic [31:0]  o_cause
);
  logic w_ext, w_tmr, w_unused;

  assign w_ext    = i_mstatus.mie & i_mie.meie & i_mip.meip;
  assign w_tmr    = i_mstatus.mie & i_mie.mtie & i_mip.mtip;
  assign w_unused = ^{i_mstatus, i_mie, i_mip};

  always_comb begin
    o_valid  = 1'b0;
    o_is_irq = 1'b0;
    o_cause  = '0;
    if (i_exc_req) begin
      o_valid = 1'b1;
      o_cause = i_exc_code;
    end else if (w_ext) begin
      o_valid  = 1'b1;
      o_is_irq = 1'b1;
      o_cause  = M_EXT_INT;
    end else if (w_tmr) begin
      o_valid  = 1'b1;
      o_is_irq = 1'b1;
      o_cause  = M_TIMER_INT;
    end
  end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
//   clk, rst_n - core clock, async active-low reset
//   bus        - trap_ctrl_if.slave (core inputs, CSR write port, redirect)
// At an instruction boundary in IDLE it accepts an exception, external irq,
// timer irq or mret (in that priority), then issues one CSR write per cycle
// (mepc, mcause, mtval, mstatus for a trap; mstatus for mret) while stalling,
// and finishes with a one-cycle redirect to MTVEC or mepc.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int              XLEN  = 32,
  parameter logic [XLEN-1:0] MTVEC = HARDCODED_MTVEC
) (
  input logic         clk,
  input logic         rst_n,
  trap_ctrl_if.slave  bus
);
  localparam logic [2:0] S_IDLE     = IDLE;
  localparam logic [2:0] S_W_EPC    = W_EPC;
  localparam logic [2:0] S_W_CAUSE  = W_CAUSE;
  localparam logic [2:0] S_W_TVAL   = W_TVAL;
  localparam logic [2:0] S_W_STATUS = W_STATUS;
  localparam logic [2:0] S_M_STATUS = M_STATUS;
  localparam logic [2:0] S_REDIRECT = REDIRECT;

  logic [2:0]      r_state, w_nstate;
  logic            r_is_mret;
  logic [31:0]     r_cause;
  logic [XLEN-1:0] r_tval;
  mstatus_csr_t    r_mstatus;

  logic            r_we;
  logic [11:0]     r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic            r_redirect;

  logic            w_valid, w_is_irq;
  logic [31:0]     w_cause;
  logic            w_acc_trap, w_acc_mret;
  logic            w_we;
  logic [11:0]     w_waddr;
  logic [XLEN-1:0] w_wdata;
  logic            w_unused;

  trap_prio_enc u_prio (
    .i_exc_req  (bus.exc_req_i),
    .i_exc_code (bus.exc_code_i),
    .i_mstatus  (bus.mstatus_i),
    .i_mie      (bus.mie_i),
    .i_mip      (bus.mip_i),
    .o_valid    (w_valid),
    .o_is_irq   (w_is_irq),
    .o_cause    (w_cause)
  );

  // mret only wins when no trap source is active, so an irq coincident
  // with mret is taken and the mret re-executes after the handler.
  assign w_acc_trap = (r_state == S_IDLE) & bus.boundary_i & w_valid;
  assign w_acc_mret = (r_state == S_IDLE) & bus.boundary_i & ~w_valid & bus.mret_i;
  assign w_unused   = ^bus.trap_pc_i[1:0];

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc_trap)      w_nstate = S_W_EPC;
        else if (w_acc_mret) w_nstate = S_M_STATUS;
      end
      S_W_EPC:    w_nstate = S_W_CAUSE;
      S_W_CAUSE:  w_nstate = S_W_TVAL;
      S_W_TVAL:   w_nstate = S_W_STATUS;
      S_W_STATUS: w_nstate = S_REDIRECT;
      S_M_STATUS: w_nstate = S_REDIRECT;
      default:    w_nstate = S_IDLE;
    endcase
  end

  // Write port is registered: decode the write belonging to the next state.
  // W_EPC and M_STATUS are only entered from acceptance, so their data comes
  // straight from the inputs; later writes use the captured values.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    case (w_nstate)
      S_W_EPC: begin
        w_we    = 1'b1;
        w_waddr = CSR_MEPC;
        w_wdata = {bus.trap_pc_i[XLEN-1:2], 2'b00};
      end
      S_W_CAUSE: begin
        w_we    = 1'b1;
        w_waddr = CSR_MCAUSE;
        w_wdata = r_cause;
      end
      S_W_TVAL: begin
        w_we    = 1'b1;
        w_waddr = CSR_MTVAL;
        w_wdata = r_tval;
      end
      S_W_STATUS: begin
        w_we    = 1'b1;
        w_waddr = CSR_MSTATUS;
        w_wdata = trap_entry_status(r_mstatus);
      end
      S_M_STATUS: begin
        w_we    = 1'b1;
        w_waddr = CSR_MSTATUS;
        w_wdata = mret_status(bus.mstatus_i);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_is_mret  <= 1'b0;
      r_cause    <= '0;
      r_tval     <= '0;
      r_mstatus  <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_redirect <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_we       <= w_we;
      r_waddr    <= w_waddr;
      r_wdata    <= w_wdata;
      r_redirect <= (w_nstate == S_REDIRECT);
      if (w_acc_trap) begin
        r_is_mret <= 1'b0;
        r_cause   <= w_cause;
        r_tval    <= w_is_irq ? '0 : bus.exc_tval_i;
        r_mstatus <= bus.mstatus_i;
      end else if (w_acc_mret) begin
        r_is_mret <= 1'b1;
        r_mstatus <= bus.mstatus_i;
      end
    end
  end

  assign bus.stall_o       = (r_state != S_IDLE);
  assign bus.csr_we_o      = r_we;
  assign bus.csr_waddr_o   = r_waddr;
  assign bus.csr_wdata_o   = r_wdata;
  assign bus.redirect_o    = r_redirect;
  assign bus.redirect_pc_o = r_redirect ? (r_is_mret ? bus.mepc_i : MTVEC) : '0;
  assign bus.trap_taken_o  = w_acc_trap;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed bench for trap_ctrl. Expected CSR writes and
// redirects (with their cycle numbers) are queued when a sequence is started
// and checked by a monitor as the DUT produces them.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(32)) bus();

  trap_ctrl #(.XLEN(32), .MTVEC(32'h8000_0004)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int cyc; logic [11:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic [31:0] pc; } rd_t;

  wr_t exp_w[$];
  rd_t exp_r[$];
  int  cyc = 0;
  int  acc_cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input int off, input logic [11:0] addr, input logic [31:0] data);
    wr_t e;
    e.cyc = acc_cyc + off; e.addr = addr; e.data = data;
    exp_w.push_back(e);
  endtask

  task automatic push_r(input int off, input logic [31:0] pc);
    rd_t e;
    e.cyc = acc_cyc + off; e.pc = pc;
    exp_r.push_back(e);
  endtask

  // Monitor: every write/redirect must match the head of its queue.
  always @(negedge clk) begin : mon
    wr_t ew;
    rd_t er;
    if (rst_n) begin
      if (bus.csr_we_o) begin
        if (exp_w.size() == 0) chk("unexpected_write", {31'h0, bus.csr_we_o}, 32'h0);
        else begin
          ew = exp_w.pop_front();
          chk("wr_cycle", cyc, ew.cyc);
          chk("wr_addr", {20'h0, bus.csr_waddr_o}, {20'h0, ew.addr});
          chk("wr_data", bus.csr_wdata_o, ew.data);
        end
      end else begin
        chk("idle_waddr", {20'h0, bus.csr_waddr_o}, 32'h0);
        chk("idle_wdata", bus.csr_wdata_o, 32'h0);
      end
      if (bus.redirect_o) begin
        if (exp_r.size() == 0) chk("unexpected_redirect", {31'h0, bus.redirect_o}, 32'h0);
        else begin
          er = exp_r.pop_front();
          chk("rd_cycle", cyc, er.cyc);
          chk("rd_pc", bus.redirect_pc_o, er.pc);
        end
      end else begin
        chk("idle_redirect_pc", bus.redirect_pc_o, 32'h0);
      end
    end
  end

  // Present one boundary cycle (cycle 0), check trap_taken/stall, then drop it.
  task automatic issue(input logic bnd, input logic exc, input logic [31:0] code,
                       input logic [31:0] pc, input logic [31:0] tval, input logic mret,
                       input logic [31:0] ms, input logic [31:0] ie, input logic [31:0] ip,
                       input logic exp_taken, input string tag);
    bus.boundary_i = bnd;  bus.exc_req_i = exc;  bus.exc_code_i = code;
    bus.trap_pc_i  = pc;   bus.exc_tval_i = tval; bus.mret_i    = mret;
    bus.mstatus_i  = ms;   bus.mie_i      = ie;   bus.mip_i     = ip;
    @(negedge clk);
    acc_cyc = cyc;
    chk({tag, "_taken"}, {31'h0, bus.trap_taken_o}, {31'h0, exp_taken});
    chk({tag, "_stall0"}, {31'h0, bus.stall_o}, 32'h0);
    @(posedge clk); #1;
    bus.boundary_i = 1'b0; bus.exc_req_i = 1'b0; bus.mret_i = 1'b0;
  endtask

  // Expect n stalled cycles, then idle with every queued item consumed.
  task automatic stall_run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_stall"}, {31'h0, bus.stall_o}, 32'h1);
      chk({tag, "_taken_low"}, {31'h0, bus.trap_taken_o}, 32'h0);
    end
    @(negedge clk);
    chk({tag, "_stall_end"}, {31'h0, bus.stall_o}, 32'h0);
    chk({tag, "_drain"}, 32'(exp_w.size() + exp_r.size()), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.boundary_i = 0; bus.exc_req_i = 0; bus.exc_code_i = 0; bus.exc_tval_i = 0;
    bus.trap_pc_i = 0;  bus.mret_i = 0;    bus.mstatus_i = 0;  bus.mie_i = 0;
    bus.mip_i = 0;      bus.mepc_i = 32'h8000_0300;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'h0, bus.stall_o}, 32'h0);
    chk("rst_we", {31'h0, bus.csr_we_o}, 32'h0);
    chk("rst_waddr", {20'h0, bus.csr_waddr_o}, 32'h0);
    chk("rst_wdata", bus.csr_wdata_o, 32'h0);
    chk("rst_redirect", {31'h0, bus.redirect_o}, 32'h0);
    chk("rst_redirect_pc", bus.redirect_pc_o, 32'h0);
    chk("rst_taken", {31'h0, bus.trap_taken_o}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: illegal instruction
    issue(1, 1, 32'd2, 32'h8000_0100, 32'h0000_FFFF, 0, 32'h8, 0, 0, 1, "t1");
    push_w(1, 12'h341, 32'h8000_0100); push_w(2, 12'h342, 32'd2);
    push_w(3, 12'h343, 32'h0000_FFFF); push_w(4, 12'h300, 32'h0000_1880);
    push_r(5, 32'h8000_0004);
    stall_run(5, "t1");

    // 2: external beats timer, tval forced to 0
    issue(1, 0, 0, 32'h8000_0200, 32'h1234, 0, 32'h8, 32'h880, 32'h880, 1, "t2");
    push_w(1, 12'h341, 32'h8000_0200); push_w(2, 12'h342, 32'h8000_000B);
    push_w(3, 12'h343, 32'h0);         push_w(4, 12'h300, 32'h0000_1880);
    push_r(5, 32'h8000_0004);
    stall_run(5, "t2");

    // 2b: timer alone
    issue(1, 0, 0, 32'h8000_0204, 32'h0, 0, 32'h8, 32'h880, 32'h080, 1, "t2b");
    push_w(1, 12'h341, 32'h8000_0204); push_w(2, 12'h342, 32'h8000_0007);
    push_w(3, 12'h343, 32'h0);         push_w(4, 12'h300, 32'h0000_1880);
    push_r(5, 32'h8000_0004);
    stall_run(5, "t2b");

    // 3: masked interrupts, then ECALL still taken
    issue(1, 0, 0, 32'h8000_0300, 32'h0, 0, 32'h0, 32'h880, 32'h880, 0, "t3m");
    stall_run(0, "t3m");
    issue(1, 1, 32'd11, 32'h8000_0300, 32'h0, 0, 32'h0, 32'h880, 32'h880, 1, "t3");
    push_w(1, 12'h341, 32'h8000_0300); push_w(2, 12'h342, 32'd11);
    push_w(3, 12'h343, 32'h0);         push_w(4, 12'h300, 32'h0000_1800);
    push_r(5, 32'h8000_0004);
    stall_run(5, "t3");

    // 3b: no boundary -> exception not accepted
    issue(0, 1, 32'd2, 32'h8000_0310, 32'h1, 0, 32'h8, 0, 0, 0, "t3b");
    stall_run(0, "t3b");

    // 4: mret
    issue(1, 0, 0, 32'h8000_0400, 32'h0, 1, 32'h80, 0, 0, 0, "t4");
    push_w(1, 12'h300, 32'h0000_1888); push_r(2, 32'h8000_0300);
    stall_run(2, "t4");

    // 4b: mret keeps unrelated fields, redirect follows mepc_i
    bus.mepc_i = 32'h8000_1234;
    issue(1, 0, 0, 32'h8000_0404, 32'h0, 1, 32'h20A2, 0, 0, 0, "t4b");
    push_w(1, 12'h300, 32'h0000_38AA); push_r(2, 32'h8000_1234);
    stall_run(2, "t4b");

    // 5a: exception + mret: exception only, mepc low bits cleared
    issue(1, 1, 32'd3, 32'h8000_0403, 32'h8000_0403, 1, 32'h202A, 0, 0, 1, "t5a");
    push_w(1, 12'h341, 32'h8000_0400); push_w(2, 12'h342, 32'd3);
    push_w(3, 12'h343, 32'h8000_0403); push_w(4, 12'h300, 32'h0000_38A2);
    push_r(5, 32'h8000_0004);
    stall_run(5, "t5a");

    // 5b: interrupt + mret: interrupt taken at the mret's pc
    issue(1, 0, 0, 32'h8000_0600, 32'h55, 1, 32'h8, 32'h800, 32'h800, 1, "t5b");
    push_w(1, 12'h341, 32'h8000_0600); push_w(2, 12'h342, 32'h8000_000B);
    push_w(3, 12'h343, 32'h0);         push_w(4, 12'h300, 32'h0000_1880);
    push_r(5, 32'h8000_0004);
    stall_run(5, "t5b");

    // 5c: exception pulsed during W_CAUSE is ignored
    issue(1, 1, 32'd2, 32'h8000_0500, 32'hDEAD, 0, 32'h8, 0, 0, 1, "t5c");
    push_w(1, 12'h341, 32'h8000_0500); push_w(2, 12'h342, 32'd2);
    push_w(3, 12'h343, 32'hDEAD);      push_w(4, 12'h300, 32'h0000_1880);
    push_r(5, 32'h8000_0004);
    @(negedge clk);
    chk("t5c_stall_c1", {31'h0, bus.stall_o}, 32'h1);
    @(posedge clk); #1;
    bus.boundary_i = 1; bus.exc_req_i = 1; bus.exc_code_i = 32'd11; bus.mret_i = 1;
    @(negedge clk);
    chk("t5c_busy_taken", {31'h0, bus.trap_taken_o}, 32'h0);
    chk("t5c_stall_c2", {31'h0, bus.stall_o}, 32'h1);
    @(posedge clk); #1;
    bus.boundary_i = 0; bus.exc_req_i = 0; bus.mret_i = 0;
    stall_run(3, "t5c");

    // 6: reset during W_TVAL
    issue(1, 1, 32'd2, 32'h8000_0700, 32'h77, 0, 32'h8, 0, 0, 1, "t6");
    push_w(1, 12'h341, 32'h8000_0700); push_w(2, 12'h342, 32'd2);
    push_w(3, 12'h343, 32'h77);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_stall", {31'h0, bus.stall_o}, 32'h0);
    chk("t6_rst_we", {31'h0, bus.csr_we_o}, 32'h0);
    chk("t6_rst_waddr", {20'h0, bus.csr_waddr_o}, 32'h0);
    chk("t6_rst_wdata", bus.csr_wdata_o, 32'h0);
    chk("t6_rst_redirect", {31'h0, bus.redirect_o}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_rst_hold_we", {31'h0, bus.csr_we_o}, 32'h0);
      chk("t6_rst_hold_stall", {31'h0, bus.stall_o}, 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stall_run(0, "t6_post");

    // 6b: normal trap after reset release
    issue(1, 1, 32'd11, 32'h8000_0800, 32'h0, 0, 32'h8, 0, 0, 1, "t6b");
    push_w(1, 12'h341, 32'h8000_0800); push_w(2, 12'h342, 32'd11);
    push_w(3, 12'h343, 32'h0);         push_w(4, 12'h300, 32'h0000_1880);
    push_r(5, 32'h8000_0004);
    stall_run(5, "t6b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
